// File: rtl/mc_pkg.sv
// mc_pkg: shared constants for the multicycle MIPS datapath.
//   ALU operation codes, ALUSrcB select encodings, primary opcodes,
//   and a sign-extension helper for the 16-bit immediate.
package mc_pkg;

  localparam logic [3:0] ALU_AND  = 4'b0000;
  localparam logic [3:0] ALU_OR   = 4'b0001;
  localparam logic [3:0] ALU_ADD  = 4'b0010;
  localparam logic [3:0] ALU_SLLV = 4'b0011;
  localparam logic [3:0] ALU_SRLV = 4'b0101;
  localparam logic [3:0] ALU_SUB  = 4'b0110;
  localparam logic [3:0] ALU_SLT  = 4'b0111;
  localparam logic [3:0] ALU_SRAV = 4'b1000;
  localparam logic [3:0] ALU_SLL  = 4'b1011;
  localparam logic [3:0] ALU_SRA  = 4'b1100;
  localparam logic [3:0] ALU_SRL  = 4'b1101;

  localparam logic [1:0] SRCB_B    = 2'b00;
  localparam logic [1:0] SRCB_FOUR = 2'b01;
  localparam logic [1:0] SRCB_IMM  = 2'b10;
  localparam logic [1:0] SRCB_BR   = 2'b11;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;

  function automatic logic [31:0] sign_ext(input logic [15:0] imm);
    return {{16{imm[15]}}, imm};
  endfunction

endpackage

// File: rtl/mc_regfile.sv
// mc_regfile: 32x32 register file, two operand read ports, one debug read
// port, one write port.
//   clk, reset      : clock, synchronous active-low clear of all registers
//   we, wa, wd      : write enable / address / data (r0 writes dropped)
//   ra1/rd1, ra2/rd2: combinational operand reads (r0 reads 0)
//   ra3/rd3         : combinational debug read
// Reads see the pre-edge contents, so a same-cycle write is not forwarded.
module mc_regfile (
  input  logic        clk,
  input  logic        reset,
  input  logic        we,
  input  logic [4:0]  wa,
  input  logic [31:0] wd,
  input  logic [4:0]  ra1,
  input  logic [4:0]  ra2,
  input  logic [4:0]  ra3,
  output logic [31:0] rd1,
  output logic [31:0] rd2,
  output logic [31:0] rd3
);

  logic [31:0][31:0] rf_q, rf_d;

  always_comb begin
    rf_d = rf_q;
    if (we && (wa != 5'd0)) rf_d[wa] = wd;
  end

  always_ff @(posedge clk) begin
    if (!reset) rf_q <= '0;
    else        rf_q <= rf_d;
  end

  assign rd1 = (ra1 == 5'd0) ? 32'd0 : rf_q[ra1];
  assign rd2 = (ra2 == 5'd0) ? 32'd0 : rf_q[ra2];
  assign rd3 = (ra3 == 5'd0) ? 32'd0 : rf_q[ra3];

endmodule

// File: rtl/mc_datapath.sv
// mc_datapath: multicycle MIPS datapath driven by an external controller.
//   Holds PC, IR, MDR, A, B, ALUOut, the register file and the ALU.
//   Inputs : per-state control word (PCEn, IorD, IRWrite, PCSrc, ALUSrcA,
//            ALUSrcB, ALUControl, ShamtSel, RegWrite, RegDst, MemToReg),
//            MemRData from the unified memory, dbg_raddr.
//   Outputs: MemAddr/MemWData to memory, Opcode/Funct/Zero to the controller,
//            dbg_rdata (register contents, or 0 when DBG_EN=0).
module mc_datapath
  import mc_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter bit          DBG_EN   = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        PCEn,
  input  logic        IorD,
  input  logic        IRWrite,
  input  logic        PCSrc,
  input  logic        ALUSrcA,
  input  logic [1:0]  ALUSrcB,
  input  logic [3:0]  ALUControl,
  input  logic        ShamtSel,
  input  logic        RegWrite,
  input  logic        RegDst,
  input  logic        MemToReg,
  output logic [31:0] MemAddr,
  output logic [31:0] MemWData,
  input  logic [31:0] MemRData,
  output logic [5:0]  Opcode,
  output logic [5:0]  Funct,
  output logic        Zero,
  input  logic [4:0]  dbg_raddr,
  output logic [31:0] dbg_rdata
);

  logic [31:0] pc_q, pc_d, ir_q, ir_d, mdr_q, mdr_d;
  logic [31:0] a_q, a_d, b_q, b_d, aluout_q, aluout_d;
  logic [31:0] rd1, rd2, rd3, sign_imm, src_a, src_b, alu_result;
  logic [4:0]  shamt;

  mc_regfile u_rf (
    .clk   (clk),
    .reset (reset),
    .we    (RegWrite),
    .wa    (RegDst ? ir_q[15:11] : ir_q[20:16]),
    .wd    (MemToReg ? mdr_q : aluout_q),
    .ra1   (ir_q[25:21]),
    .ra2   (ir_q[20:16]),
    .ra3   (dbg_raddr),
    .rd1   (rd1),
    .rd2   (rd2),
    .rd3   (rd3)
  );

  assign sign_imm = sign_ext(ir_q[15:0]);

  // ALU. Fixed-shift codes always take IR[10:6]; ShamtSel forces it for
  // the variable shifts too. Unknown codes yield 0.
  always_comb begin
    src_a = ALUSrcA ? a_q : pc_q;
    case (ALUSrcB)
      SRCB_B:    src_b = b_q;
      SRCB_FOUR: src_b = 32'd4;
      SRCB_IMM:  src_b = sign_imm;
      default:   src_b = {sign_imm[29:0], 2'b00};
    endcase
    if (ShamtSel || ALUControl == ALU_SLL || ALUControl == ALU_SRL ||
        ALUControl == ALU_SRA)
      shamt = ir_q[10:6];
    else
      shamt = src_a[4:0];
    case (ALUControl)
      ALU_AND:           alu_result = src_a & src_b;
      ALU_OR:            alu_result = src_a | src_b;
      ALU_ADD:           alu_result = src_a + src_b;
      ALU_SUB:           alu_result = src_a - src_b;
      ALU_SLT:           alu_result = {31'd0, $signed(src_a) < $signed(src_b)};
      ALU_SLLV, ALU_SLL: alu_result = src_b << shamt;
      ALU_SRLV, ALU_SRL: alu_result = src_b >> shamt;
      ALU_SRAV, ALU_SRA: alu_result = $unsigned($signed(src_b) >>> shamt);
      default:           alu_result = 32'd0;
    endcase
  end

  always_comb begin
    pc_d     = pc_q;
    if (PCEn) pc_d = PCSrc ? aluout_q : alu_result;
    ir_d     = IRWrite ? MemRData : ir_q;
    mdr_d    = MemRData;
    a_d      = rd1;
    b_d      = rd2;
    aluout_d = alu_result;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      pc_q     <= RESET_PC;
      ir_q     <= '0;
      mdr_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      aluout_q <= '0;
    end else begin
      pc_q     <= pc_d;
      ir_q     <= ir_d;
      mdr_q    <= mdr_d;
      a_q      <= a_d;
      b_q      <= b_d;
      aluout_q <= aluout_d;
    end
  end

  assign MemAddr  = IorD ? aluout_q : pc_q;
  assign MemWData = b_q;
  assign Opcode   = ir_q[31:26];
  assign Funct    = ir_q[5:0];
  assign Zero     = (alu_result == 32'd0);

  generate
    if (DBG_EN) begin : g_dbg
      assign dbg_rdata = rd3;
    end else begin : g_nodbg
      assign dbg_rdata = 32'd0;
    end
  endgenerate

endmodule

// File: tb/tb_mc_datapath.sv
module tb_mc_datapath;
  import mc_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, PCEn, IorD, IRWrite, PCSrc, ALUSrcA, ShamtSel;
  logic        RegWrite, RegDst, MemToReg, Zero;
  logic [1:0]  ALUSrcB;
  logic [3:0]  ALUControl;
  logic [31:0] MemAddr, MemWData, MemRData, dbg_rdata;
  logic [5:0]  Opcode, Funct;
  logic [4:0]  dbg_raddr;

  logic [31:0] mem [64];
  logic        mem_mode;
  logic [31:0] rdata_v;
  assign MemRData = mem_mode ? mem[MemAddr[7:2]] : rdata_v;

  mc_datapath #(.RESET_PC(32'h0), .DBG_EN(1'b1)) dut (
    .clk(clk), .reset(reset), .PCEn(PCEn), .IorD(IorD), .IRWrite(IRWrite),
    .PCSrc(PCSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
    .ALUControl(ALUControl), .ShamtSel(ShamtSel), .RegWrite(RegWrite),
    .RegDst(RegDst), .MemToReg(MemToReg), .MemAddr(MemAddr),
    .MemWData(MemWData), .MemRData(MemRData), .Opcode(Opcode), .Funct(Funct),
    .Zero(Zero), .dbg_raddr(dbg_raddr), .dbg_rdata(dbg_rdata)
  );

  // Architectural model: visible state of the datapath as plain variables.
  logic [31:0] m_pc, m_ir, m_mdr, m_a, m_b, m_out;
  logic [31:0] m_rf [32];
  int errors = 0, checks = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] m_alu(input logic [3:0] op, input logic [31:0] x,
                                        input logic [31:0] y, input logic [4:0] sh);
    logic [31:0] ones;
    ones = 32'hFFFF_FFFF;
    case (op)
      4'b0000: return x & y;
      4'b0001: return x | y;
      4'b0010: return x + y;
      4'b0110: return x - y;
      4'b0111: return ((x[31] != y[31]) ? x[31] : (x < y)) ? 32'd1 : 32'd0;
      4'b0011, 4'b1011: return y << sh;
      4'b0101, 4'b1101: return y >> sh;
      4'b1000, 4'b1100: return (y >> sh) | ({32{y[31]}} & ~(ones >> sh));
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic [31:0] m_result();
    logic [31:0] x, y, imm;
    logic [4:0]  sh;
    imm = {{16{m_ir[15]}}, m_ir[15:0]};
    x = ALUSrcA ? m_a : m_pc;
    case (ALUSrcB)
      2'b00: y = m_b;
      2'b01: y = 32'd4;
      2'b10: y = imm;
      default: y = imm * 4;
    endcase
    sh = (ShamtSel || ALUControl == 4'b1011 || ALUControl == 4'b1101 ||
          ALUControl == 4'b1100) ? m_ir[10:6] : x[4:0];
    return m_alu(ALUControl, x, y, sh);
  endfunction

  function automatic logic [31:0] m_addr();
    return IorD ? m_out : m_pc;
  endfunction

  // Compare every observable output against the model after inputs settle.
  task automatic settle();
    logic [31:0] res;
    #1;
    res = m_result();
    chk("MemAddr",  MemAddr,  m_addr());
    chk("MemWData", MemWData, m_b);
    chk("Opcode",   {26'd0, Opcode}, {26'd0, m_ir[31:26]});
    chk("Funct",    {26'd0, Funct},  {26'd0, m_ir[5:0]});
    chk("Zero",     {31'd0, Zero},   {31'd0, res == 32'd0});
    chk("dbg_rdata", dbg_rdata, m_rf[dbg_raddr]);
  endtask

  task automatic tick();
    logic [31:0] res, rd, na, nb, nwd;
    logic [4:0]  nwa;
    res = m_result();
    rd  = mem_mode ? mem[m_addr() >> 2 & 32'h3F] : rdata_v;
    nwa = RegDst ? m_ir[15:11] : m_ir[20:16];
    nwd = MemToReg ? m_mdr : m_out;
    na  = m_rf[m_ir[25:21]];
    nb  = m_rf[m_ir[20:16]];
    @(posedge clk);
    if (!reset) begin
      m_pc = 32'h0; m_ir = 0; m_mdr = 0; m_a = 0; m_b = 0; m_out = 0;
      for (int i = 0; i < 32; i++) m_rf[i] = 0;
    end else begin
      if (PCEn) m_pc = PCSrc ? m_out : res;
      if (IRWrite) m_ir = rd;
      if (RegWrite && nwa != 5'd0) m_rf[nwa] = nwd;
      m_mdr = rd; m_a = na; m_b = nb; m_out = res;
    end
    @(negedge clk);
  endtask

  task automatic step();
    settle();
    tick();
  endtask

  task automatic idle();
    reset = 1; PCEn = 0; IorD = 0; IRWrite = 0; PCSrc = 0; ALUSrcA = 0;
    ALUSrcB = 2'b00; ALUControl = ALU_ADD; ShamtSel = 0; RegWrite = 0;
    RegDst = 0; MemToReg = 0;
  endtask

  task automatic peek(input logic [4:0] r, input logic [31:0] exp, input string nm);
    dbg_raddr = r;
    #1;
    chk(nm, dbg_rdata, exp);
  endtask

  // Write val to register r through the lw-style MDR path.
  task automatic load_reg(input logic [4:0] r, input logic [31:0] val);
    idle(); rdata_v = {OP_LW, 5'd0, r, 16'd0}; IRWrite = 1; step();
    idle(); rdata_v = val; step();
    idle(); RegWrite = 1; MemToReg = 1; step();
    idle();
  endtask

  task automatic rtype(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                       input logic [4:0] sh, input logic [3:0] op, input logic ssel);
    idle(); rdata_v = {OP_RTYPE, rs, rt, rd, sh, 6'h20}; IRWrite = 1; step();
    idle(); step();
    idle(); ALUSrcA = 1; ALUSrcB = SRCB_B; ALUControl = op; ShamtSel = ssel; step();
    idle(); RegWrite = 1; RegDst = 1; step();
    idle();
  endtask

  task automatic beq_fetch_s1(input logic [31:0] instr);
    idle(); rdata_v = instr; IRWrite = 1; PCEn = 1; ALUSrcB = SRCB_FOUR; step();
    idle(); ALUSrcB = SRCB_BR; step();
  endtask

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 32'd0;
    mem[0] = 32'h8C08_0004;
    mem[1] = 32'hDEAD_BEEF;
    mem_mode = 1; rdata_v = 32'h1357_9BDF; dbg_raddr = 0;

    // Reset with enables asserted: reset must win.
    idle(); reset = 0; PCEn = 1; RegWrite = 1; IRWrite = 1;
    tick(); tick();
    idle();
    #1;
    chk("reset_pc", MemAddr, 32'h0);
    chk("reset_opcode", {26'd0, Opcode}, 32'd0);
    for (int i = 0; i < 32; i++) begin
      dbg_raddr = i[4:0];
      step();
      chk("reset_rf", dbg_rdata, 32'd0);
    end

    // lw r8, 4(r0): S0..S4
    idle(); IRWrite = 1; PCEn = 1; ALUSrcB = SRCB_FOUR; step();
    idle(); #1;
    chk("fetch_ir_op", {26'd0, Opcode}, {26'd0, 6'b100011});
    chk("fetch_pc", MemAddr, 32'd4);
    ALUSrcB = SRCB_BR; step();                        // S1
    idle(); ALUSrcA = 1; ALUSrcB = SRCB_IMM; step();  // S2
    idle(); IorD = 1; #1;
    chk("lw_s3_addr", MemAddr, 32'd4);
    step();                                           // S3
    idle(); RegWrite = 1; MemToReg = 1; step();       // S4
    idle(); peek(5'd8, 32'hDEAD_BEEF, "lw_r8");
    mem_mode = 0;

    // R-type
    load_reg(5'd1, 32'd5); load_reg(5'd2, 32'd7);
    rtype(5'd1, 5'd2, 5'd3, 5'd0, ALU_SUB, 1'b0); peek(5'd3, 32'hFFFF_FFFE, "sub");
    rtype(5'd1, 5'd2, 5'd3, 5'd0, ALU_SLT, 1'b0); peek(5'd3, 32'd1, "slt");
    load_reg(5'd4, 32'h8000_0000);
    rtype(5'd0, 5'd4, 5'd9, 5'd4, ALU_SRA, 1'b0); peek(5'd9, 32'hF800_0000, "sra");
    load_reg(5'd6, 32'd36); load_reg(5'd7, 32'hF0);
    rtype(5'd6, 5'd7, 5'd10, 5'd0, ALU_SRLV, 1'b0); peek(5'd10, 32'h0F, "srlv");
    rtype(5'd6, 5'd7, 5'd11, 5'd2, ALU_SRLV, 1'b1); peek(5'd11, 32'h3C, "srlv_shamtsel");

    // r0 stays zero; read-during-write gives old value to B
    load_reg(5'd0, 32'h1234); peek(5'd0, 32'd0, "r0_zero");
    load_reg(5'd5, 32'h11);
    idle(); rdata_v = 32'h22; step();
    idle(); RegWrite = 1; MemToReg = 1; #1;
    chk("rdw_before", MemWData, 32'h11);
    step();
    idle(); #1; chk("rdw_old", MemWData, 32'h11);
    step();
    idle(); #1; chk("rdw_new", MemWData, 32'h22);
    peek(5'd5, 32'h22, "rdw_r5");

    // beq taken from PC=8 (registers cleared, r1==r2)
    idle(); reset = 0; tick();
    idle(); rdata_v = 32'd0; IRWrite = 1; PCEn = 1; ALUSrcB = SRCB_FOUR; step();
    beq_fetch_s1({OP_BEQ, 5'd1, 5'd2, 16'd3});
    idle(); ALUSrcA = 1; ALUControl = ALU_SUB; PCEn = 1; PCSrc = 1; #1;
    chk("beq_zero", {31'd0, Zero}, 32'd1);
    step();
    idle(); #1; chk("beq_pc", MemAddr, 32'd20);

    // beq not taken: r1=5, r2=0, PC 20 -> 24, PCEn held low
    load_reg(5'd1, 32'd5);
    beq_fetch_s1({OP_BEQ, 5'd1, 5'd2, 16'd3});
    idle(); ALUSrcA = 1; ALUControl = ALU_SUB; PCSrc = 1; #1;
    chk("bne_zero", {31'd0, Zero}, 32'd0);
    step();
    idle(); #1; chk("bne_pc", MemAddr, 32'd24);

    // Randomized control words and memory data
    for (int n = 0; n < 3000; n++) begin
      reset      = ($urandom_range(63) != 0);
      PCEn       = $urandom_range(1);
      IorD       = $urandom_range(1);
      IRWrite    = $urandom_range(1);
      PCSrc      = $urandom_range(1);
      ALUSrcA    = $urandom_range(1);
      ALUSrcB    = 2'($urandom_range(3));
      ALUControl = 4'($urandom_range(15));
      ShamtSel   = ($urandom_range(3) == 0);
      RegWrite   = $urandom_range(1);
      RegDst     = $urandom_range(1);
      MemToReg   = $urandom_range(1);
      dbg_raddr  = 5'($urandom_range(31));
      rdata_v    = $urandom;
      step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
